// File: rtl/vdp_sprite_select_if.sv
// VRAM read port between the sprite evaluation stage (master) and the VRAM arbiter (slave).
interface vdp_sprite_select_if #(
    parameter int VRAM_AW = 17
);
    logic               vram_valid;
    logic               vram_ready;
    logic [VRAM_AW-1:0] vram_address;
    logic               vram_rdata_en;
    logic [31:0]        vram_rdata;

    modport master (
        output vram_valid,
        output vram_address,
        input  vram_ready,
        input  vram_rdata_en,
        input  vram_rdata
    );

    modport slave (
        input  vram_valid,
        input  vram_address,
        output vram_ready,
        output vram_rdata_en,
        output vram_rdata
    );
endinterface

// File: rtl/vdp_sprite_select.sv
// Per-line TMS9918 sprite evaluation: scans the attribute table and keeps up to 4 visible sprites.
// Define VDP_SPRITE_8PER_LINE_EN to raise the per-line limit to 8 (widens sel_count/rd_index).
module vdp_sprite_select #(
    parameter int MAX_PLANES = 32,
    parameter int VRAM_AW    = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          line_no,
    input  logic                reg_sprite_16,
    input  logic                reg_sprite_mag,
    input  logic [6:0]          reg_sat_base,
    vdp_sprite_select_if.master vram,
    output logic                busy,
    output logic                done,
`ifdef VDP_SPRITE_8PER_LINE_EN
    output logic [3:0]          sel_count,
    input  logic [2:0]          rd_index,
`else
    output logic [2:0]          sel_count,
    input  logic [1:0]          rd_index,
`endif
    output logic [4:0]          rd_plane,
    output logic [7:0]          rd_x,
    output logic [7:0]          rd_pattern,
    output logic [7:0]          rd_color,
    output logic [3:0]          rd_row,
    output logic                fifth_flag,
    output logic [4:0]          fifth_plane
);

`ifdef VDP_SPRITE_8PER_LINE_EN
    localparam int SLOTS = 8;
    localparam int CW    = 4;
    localparam int IW    = 3;
`else
    localparam int SLOTS = 4;
    localparam int CW    = 3;
    localparam int IW    = 2;
`endif

    localparam logic [CW-1:0] SEL_MAX    = CW'(SLOTS);
    localparam logic [4:0]    LAST_PLANE = 5'(MAX_PLANES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EVAL,
        S_FIN
    } state_t;

    state_t             r_state;
    logic               r_valid;
    logic [VRAM_AW-1:0] r_addr;
    logic               r_busy;
    logic               r_done;
    logic [CW-1:0]      r_count;
    logic               r_fifth;
    logic [4:0]         r_fifth_plane;
    logic [4:0]         r_plane;
    logic [7:0]         r_line;
    logic               r_s16;
    logic               r_mag;
    logic [6:0]         r_sat;
    logic [31:0]        r_data;

    logic [4:0]         r_ent_plane   [SLOTS];
    logic [7:0]         r_ent_x       [SLOTS];
    logic [7:0]         r_ent_pattern [SLOTS];
    logic [7:0]         r_ent_color   [SLOTS];
    logic [3:0]         r_ent_row     [SLOTS];

    logic [7:0]         w_y;
    logic [7:0]         w_x;
    logic [7:0]         w_pat;
    logic [7:0]         w_col;
    logic [7:0]         w_diff;
    logic [7:0]         w_size;
    logic               w_visible;
    logic               w_full;
    logic               w_last;
    logic [3:0]         w_row;
    logic [IW-1:0]      w_slot;

    assign w_y    = r_data[7:0];
    assign w_x    = r_data[15:8];
    assign w_pat  = r_data[23:16];
    assign w_col  = r_data[31:24];

    // Unsigned wrap of line-Y-1 makes Y=209..255 behave as sprites partly above the screen.
    assign w_diff = r_line - w_y - 8'd1;

    always_comb begin
        w_size = 8'd8;
        case ({r_s16, r_mag})
            2'b00:   w_size = 8'd8;
            2'b01:   w_size = 8'd16;
            2'b10:   w_size = 8'd16;
            default: w_size = 8'd32;
        endcase
    end

    assign w_visible = (w_diff < w_size);
    assign w_full    = (r_count == SEL_MAX);
    assign w_last    = (r_plane == LAST_PLANE);
    assign w_row     = r_mag ? w_diff[4:1] : w_diff[3:0];
    assign w_slot    = r_count[IW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_valid       <= 1'b0;
            r_addr        <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_count       <= '0;
            r_fifth       <= 1'b0;
            r_fifth_plane <= '0;
            r_plane       <= '0;
            r_line        <= '0;
            r_s16         <= 1'b0;
            r_mag         <= 1'b0;
            r_sat         <= '0;
            r_data        <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                r_ent_plane[i]   <= '0;
                r_ent_x[i]       <= '0;
                r_ent_pattern[i] <= '0;
                r_ent_color[i]   <= '0;
                r_ent_row[i]     <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_line   <= line_no;
                        r_s16    <= reg_sprite_16;
                        r_mag    <= reg_sprite_mag;
                        r_sat    <= reg_sat_base;
                        r_count  <= '0;
                        r_fifth  <= 1'b0;
                        r_plane  <= '0;
                        r_busy   <= 1'b1;
                        r_valid  <= 1'b1;
                        r_addr   <= VRAM_AW'({reg_sat_base, 5'd0});
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (vram.vram_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (vram.vram_rdata_en) begin
                        r_data  <= vram.vram_rdata;
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (w_y == 8'd208) begin
                        r_fifth_plane <= r_plane;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= S_FIN;
                    end else if (w_visible && w_full) begin
                        r_fifth       <= 1'b1;
                        r_fifth_plane <= r_plane;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= S_FIN;
                    end else begin
                        if (w_visible) begin
                            r_ent_plane[w_slot]   <= r_plane;
                            r_ent_x[w_slot]       <= w_x;
                            r_ent_pattern[w_slot] <= r_s16 ? {w_pat[7:2], 2'b00} : w_pat;
                            r_ent_color[w_slot]   <= w_col;
                            r_ent_row[w_slot]     <= w_row;
                            r_count               <= r_count + CW'(1);
                        end
                        if (w_last) begin
                            r_fifth_plane <= r_plane;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                            r_state       <= S_FIN;
                        end else begin
                            r_plane <= r_plane + 5'd1;
                            r_valid <= 1'b1;
                            r_addr  <= VRAM_AW'({r_sat, r_plane + 5'd1});
                            r_state <= S_REQ;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign vram.vram_valid   = r_valid;
    assign vram.vram_address = r_addr;
    assign busy              = r_busy;
    assign done              = r_done;
    assign sel_count         = r_count;
    assign fifth_flag        = r_fifth;
    assign fifth_plane       = r_fifth_plane;

    assign rd_plane   = r_ent_plane[rd_index];
    assign rd_x       = r_ent_x[rd_index];
    assign rd_pattern = r_ent_pattern[rd_index];
    assign rd_color   = r_ent_color[rd_index];
    assign rd_row     = r_ent_row[rd_index];

endmodule
